vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
// - Shares one single-port 160x120x3b pixel RAM between VGA scan-out (read) and a host writer (write).
// - Scan-out is prefetched from the VGA_LOGIC counters (hor_count/ver_count); pix_rgb feeds VGA_LOGIC rgb_in.
// - Each RAM word covers a 4x4 block of 640x480 pixels: one display read every 4 clocks in active video;
//   remaining slots and all blanking slots go to a hardware clear engine, then to host writes.
// PARAMETERS
// - H_ACTIVE 640 / V_ACTIVE 480 : visible pixels / lines
// - H_TOTAL 800 / V_TOTAL 525   : full line / frame period (counter wrap points)
// - FB_W 160 / FB_H 120         : framebuffer words per row / rows (= active >> SCALE_LOG2)
// - SCALE_LOG2 2                : log2 of the pixel-replication factor
// PORTS
// - clk        in  1   pixel clock, same clock as VGA_LOGIC
// - rst_n      in  1   asynchronous reset, active low
// - hcount     in  10  VGA_LOGIC hor_count
// - vcount     in  10  VGA_LOGIC ver_count
// - ram_addr   out 15  RAM address (registered); addr = y*160 + x
// - ram_we     out 1   RAM write enable (registered)
// - ram_wdata  out 3   RAM write data (registered)
// - ram_rdata  in  3   RAM read data, valid 1 clk after the RAM samples ram_addr
// - pix_rgb    out 3   pixel colour to VGA_LOGIC rgb_in, {b,g,r}
// - wr_valid   in  1   host write request
// - wr_ready   out 1   host write accepted when wr_valid && wr_ready
// - wr_x       in  8   framebuffer column 0..159
// - wr_y       in  7   framebuffer row 0..119
// - wr_rgb     in  3   write colour
// - clr_req    in  1   single-cycle pulse: fill whole framebuffer with clr_rgb
// - clr_rgb    in  3   clear colour, sampled on the clr_req cycle
// - clr_busy   out 1   clear in progress
// - err_oor    out 1   sticky: an out-of-range write was accepted and dropped
// BEHAVIOUR
// - Reset: ram_addr=0, ram_we=0, ram_wdata=0, pix_rgb=0, clr_busy=0, err_oor=0, pending buffer empty, state IDLE.
//   Reset mid-clear aborts immediately; no further RAM writes.
// - Look-ahead: nx=hcount+2, wrapping past H_TOTAL-1 into 0/1 with ny=vcount+1 (vcount V_TOTAL-1 wraps to 0).
//   Display slot when nx[1:0]==0 && nx<H_ACTIVE && ny<V_ACTIVE.
//   Slot issues read, addr=(ny>>2)*160+(nx>>2), as shift-add, 15b, no multiplier.
// - Display timing: RAM data valid in the cycle hcount==nx; latched into pix_word at that edge; held 4 clks.
//   pix_rgb=pix_word in active region, else 0.
// - Slot priority per cycle: display read > clear write > pending host write > idle (ram_we=0).
//   ram_we=1 only in non-display slots.
// - Host handshake: 1-entry buffer. wr_ready = !pend_valid && state==IDLE.
//   Accepted write is issued in the first free slot, then the buffer empties; wr_ready rises the next cycle.
//   wr_x>=160 or wr_y>=120: accepted, dropped (no RAM write), err_oor set until reset.
// - FSM IDLE->CLEAR on clr_req while IDLE; clr_req ignored while CLEAR.
//   CLEAR writes clr_rgb to addr 0..19199 ascending, one per free slot.
//   CLEAR->IDLE after the write of addr 19199; clr_busy=1 exactly while in CLEAR.
//   A write pending at clr_req is held and issued after CLEAR, so it survives the clear.
// - Counter discontinuity (hcount jump): no error; the fetch rule is re-evaluated each cycle.
// STRUCTURE
// - Shared package vga_pkg: H_ACTIVE,H_TOTAL,V_ACTIVE,V_TOTAL,FB_W,FB_H,SCALE_LOG2, FB_WORDS=19200,
//   FB_AW=15, arbiter state enum {ST_IDLE,ST_CLEAR}.
// - One sub-module: vga_fetch_addr (hcount,vcount -> fetch_en, fetch_addr), combinational look-ahead/address.
// - Top holds the slot mux, pending buffer, clear counter/FSM, pix_word.
// TESTING
// - Behavioural sync RAM model + free-running 800x525 counter. Scoreboard: shadow RAM vs. every ram_we.
// - Reset: rst_n low mid-line -> all outputs 0, wr_ready=1 one clk after release.
// - Scan-out: RAM preloaded addr[2:0] pattern -> pixel(x,y) on pix_rgb at hcount==x+1 equals pattern
//   at (y>>2)*160+(x>>2). No ram_we in display slots.
// - Write (5,3,3'b101) during active video -> RAM addr 485 written in a non-display slot within 4 clks;
//   wr_ready low 1..3 clks.
// - Back-to-back writes in blanking -> one accept every 2 clks, addresses in order, none lost.
// - wr_x=160 -> no RAM write; err_oor=1 and stays 1.
// - clr_req, clr_rgb=3'b010, write pending -> clr_busy high, 19200 writes of 010 in order,
//   pending write issued last. Second clr_req mid-clear is ignored. rst_n pulse mid-clear stops writes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and the row-major address helper
// for the 160x120 VGA framebuffer.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 480;
  localparam int V_TOTAL    = 525;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_W       = H_ACTIVE >> SCALE_LOG2;
  localparam int FB_H       = V_ACTIVE >> SCALE_LOG2;
  localparam int FB_WORDS   = FB_W * FB_H;
  localparam int FB_AW      = 15;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } arb_state_t;

  // y*160 + x as y*128 + y*32 + x, so no multiplier is inferred
  function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
    return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/vga_fetch_addr.sv
// Look-ahead scan-out fetch: decides whether the next cycle is a display read and
// computes the framebuffer word needed two pixels ahead of the VGA counters.
module vga_fetch_addr
  import vga_pkg::*;
(
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  output logic             fetch_en,
  output logic [FB_AW-1:0] fetch_addr
);

  logic [10:0] nx_raw;
  logic [10:0] nx;
  logic [9:0]  ny;

  always_comb begin
    nx_raw = {1'b0, hcount} + 11'd2;
    nx     = nx_raw;
    ny     = vcount;
    if (nx_raw >= 11'(H_TOTAL)) begin
      nx = nx_raw - 11'(H_TOTAL);
      ny = (vcount >= 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end
    fetch_en   = (nx[1:0] == 2'b00) && (nx < 11'(H_ACTIVE)) && (ny < 10'(V_ACTIVE));
    fetch_addr = fb_addr(ny[8:2], nx[9:2]);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch, hardware clear engine and a
// one-entry host write buffer sharing one RAM port.
//   state    | meaning
//   ST_IDLE  | free slots serve the pending host write
//   ST_CLEAR | free slots write clr_color to addr 0..FB_WORDS-1
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [2:0]  ram_wdata,
  input  logic [2:0]  ram_rdata,
  output logic [2:0]  pix_rgb,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [2:0]  wr_rgb,
  input  logic        clr_req,
  input  logic [2:0]  clr_rgb,
  output logic        clr_busy,
  output logic        err_oor
);

  logic             fetch_en;
  logic [FB_AW-1:0] fetch_addr;

  arb_state_t       state, state_d;
  logic [FB_AW-1:0] clr_cnt, clr_cnt_d;
  logic [2:0]       clr_color;

  logic             pend_valid;
  logic [FB_AW-1:0] pend_addr;
  logic [2:0]       pend_rgb;
  logic             pend_issue;

  logic [FB_AW-1:0] addr_d;
  logic             we_d;
  logic [2:0]       wdata_d;

  logic [1:0]       rd_pipe;
  logic [2:0]       pix_word;
  logic             active_q;

  logic             accept;
  logic             wr_oor;

  vga_fetch_addr u_fetch (
    .hcount     (hcount),
    .vcount     (vcount),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr)
  );

  assign wr_ready = !pend_valid && (state == ST_IDLE);
  assign clr_busy = (state == ST_CLEAR);
  assign accept   = wr_valid && wr_ready;
  assign wr_oor   = (wr_x >= 8'(FB_W)) || (wr_y >= 7'(FB_H));
  assign pix_rgb  = active_q ? pix_word : 3'b000;

  always_comb begin
    state_d    = state;
    clr_cnt_d  = clr_cnt;
    addr_d     = ram_addr;
    we_d       = 1'b0;
    wdata_d    = ram_wdata;
    pend_issue = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (!fetch_en) begin
          addr_d    = clr_cnt;
          we_d      = 1'b1;
          wdata_d   = clr_color;
          clr_cnt_d = clr_cnt + 15'd1;
          if (clr_cnt == 15'(FB_WORDS - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fetch_en) begin
      addr_d = fetch_addr;
    end else if (state == ST_IDLE && !clr_req && pend_valid) begin
      // a write pending when the clear starts is held so it lands on top of the cleared image
      addr_d     = pend_addr;
      we_d       = 1'b1;
      wdata_d    = pend_rgb;
      pend_issue = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      clr_color <= 3'b000;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= 3'b000;
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      ram_addr  <= addr_d;
      ram_we    <= we_d;
      ram_wdata <= wdata_d;
      if (state == ST_IDLE && clr_req) clr_color <= clr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_rgb   <= 3'b000;
      err_oor    <= 1'b0;
    end else begin
      if (pend_issue) pend_valid <= 1'b0;
      if (accept) begin
        if (wr_oor) begin
          err_oor <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= fb_addr(wr_y, wr_x);
          pend_rgb   <= wr_rgb;
        end
      end
    end
  end

  // read data returns two cycles after the fetch decision; word is then shown for 4 pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= 2'b00;
      pix_word <= 3'b000;
      active_q <= 1'b0;
    end else begin
      rd_pipe  <= {rd_pipe[0], fetch_en};
      active_q <= (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
      if (rd_pipe[1]) pix_word <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed + randomized bench for vga_fb_arbiter with a sync RAM model, a write log and
// a reference for display-slot timing derived from the 800x525 raster rules.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = 10'd0;
  logic [9:0]  vcount = 10'd0;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata = 3'b000;
  logic [2:0]  pix_rgb;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = 8'd0;
  logic [6:0]  wr_y = 7'd0;
  logic [2:0]  wr_rgb = 3'b000;
  logic        clr_req = 1'b0;
  logic [2:0]  clr_rgb = 3'b000;
  logic        clr_busy;
  logic        err_oor;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_rgb(pix_rgb), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .clr_req(clr_req), .clr_rgb(clr_rgb), .clr_busy(clr_busy), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  logic [2:0]  mem [0:19199];
  logic        load_pat = 1'b0;

  always @(posedge clk) begin
    if (load_pat) begin
      for (int i = 0; i < 19200; i++) mem[i] <= i[2:0];
    end else if (ram_we && ram_addr < 15'd19200) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 3'b000;
  end

  function automatic bit disp_slot(input int hh, input int vv);
    int nx, ny;
    nx = hh + 2;
    ny = vv;
    if (nx >= 800) begin
      nx = nx - 800;
      ny = (vv + 1) % 525;
    end
    return (nx % 4 == 0) && (nx < 640) && (ny < 480);
  endfunction

  logic [17:0] wlog[$];
  int          prev_h = 0;
  int          prev_v = 0;
  int          viol = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      wlog.push_back({ram_addr, ram_wdata});
      if (disp_slot(prev_h, prev_v)) viol <= viol + 1;
    end
    prev_h <= int'(hcount);
    prev_v <= int'(vcount);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hcount == 10'd799) begin
        hcount = 10'd0;
        vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 10'd1;
      end
    end
  endtask

  initial begin
    int mark, low, wk, cyc, bad, x, y, c;
    logic [2:0]  rgb;
    logic [17:0] exp_q[$];
    logic [17:0] pend_exp;
    int          acc_cyc[$];
    bit          got;

    // reset with pattern preload
    hcount = 10'd790; vcount = 10'd6; load_pat = 1'b1;
    tick(3);
    chk("rst_addr", ram_addr, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_pix", pix_rgb, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_oor", err_oor, 0);
    load_pat = 1'b0;
    rst_n = 1'b1;

    // scan-out of lines 7 and 8
    mark = wlog.size();
    for (c = 0; c < 4000 && !(vcount == 10'd9 && hcount == 10'd0); c++) begin
      tick(1);
      if ((vcount == 10'd7 || vcount == 10'd8) && hcount >= 10'd1 && hcount <= 10'd640)
        chk("scan_pix", pix_rgb, (((vcount / 4) * 160) + ((hcount - 1) / 4)) % 8);
      if (vcount == 10'd7 && hcount == 10'd700) chk("blank_pix", pix_rgb, 0);
    end
    chk("scan_reached_end", (vcount == 10'd9 && hcount == 10'd0), 1);
    chk("scan_no_writes", wlog.size() - mark, 0);

    // single write during active video
    for (c = 0; c < 900 && hcount != 10'd100; c++) tick(1);
    mark = wlog.size();
    chk("b_ready_before", wr_ready, 1);
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_rgb = 3'b101;
    tick(1);
    wr_valid = 1'b0;
    low = 0; wk = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!wr_ready) low++;
      tick(1);
      if (ram_we && wk == 0) wk = k;
    end
    chk("b_write_within_4", (wk >= 1 && wk <= 4), 1);
    chk("b_ready_low_1to3", (low >= 1 && low <= 3), 1);
    chk("b_nwrites", wlog.size() - mark, 1);
    if (wlog.size() > mark) chk("b_write", wlog[mark], {15'd485, 3'b101});

    // back-to-back random writes in vertical blanking
    hcount = 10'd0; vcount = 10'd490;
    mark = wlog.size(); cyc = 0;
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 159); y = $urandom_range(0, 119); rgb = 3'($urandom_range(0, 7));
      wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_rgb = rgb;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        got = wr_ready;
        tick(1);
        cyc++;
      end
      chk("c_accepted", got, 1);
      if (got) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back({15'(y * 160 + x), rgb});
      end
    end
    wr_valid = 1'b0;
    tick(4);
    for (int i = 1; i < acc_cyc.size(); i++) chk("c_gap", acc_cyc[i] - acc_cyc[i-1], 2);
    chk("c_nwrites", wlog.size() - mark, 8);
    for (int i = 0; i < exp_q.size(); i++)
      if (mark + i < wlog.size()) chk("c_write", wlog[mark + i], exp_q[i]);

    // out-of-range writes are accepted and dropped
    mark = wlog.size();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_x = (i == 0) ? 8'd160 : 8'($urandom_range(0, 159));
      wr_y = (i == 0) ? 7'($urandom_range(0, 119)) : 7'd120;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        got = wr_ready;
        tick(1);
      end
      chk("d_accepted", got, 1);
    end
    wr_valid = 1'b0;
    tick(4);
    chk("d_oor_set", err_oor, 1);
    tick(50);
    chk("d_oor_sticky", err_oor, 1);
    chk("d_no_write", wlog.size() - mark, 0);
    chk("d_ready", wr_ready, 1);

    // reset mid-line in active video
    hcount = 10'd300; vcount = 10'd20;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("r_addr", ram_addr, 0);
    chk("r_we", ram_we, 0);
    chk("r_wdata", ram_wdata, 0);
    chk("r_pix", pix_rgb, 0);
    chk("r_busy", clr_busy, 0);
    chk("r_oor", err_oor, 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("r_ready_after", wr_ready, 1);

    // clear with a pending host write, second clr_req ignored
    hcount = 10'd0; vcount = 10'd470;
    tick(1);
    mark = wlog.size();
    x = $urandom_range(0, 159); y = $urandom_range(0, 119); rgb = 3'($urandom_range(0, 7));
    pend_exp = {15'(y * 160 + x), rgb};
    chk("e_ready_before", wr_ready, 1);
    clr_req = 1'b1; clr_rgb = 3'b010;
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_rgb = rgb;
    tick(1);
    clr_req = 1'b0; wr_valid = 1'b0; clr_rgb = 3'b111;
    chk("e_busy", clr_busy, 1);
    chk("e_ready_low", wr_ready, 0);
    for (c = 0; c < 30000 && clr_busy; c++) begin
      clr_req = (c == 3000);
      tick(1);
    end
    clr_req = 1'b0;
    chk("e_busy_fell", clr_busy, 0);
    chk("e_last_clear_at_fall", {ram_we, ram_addr}, {1'b1, 15'd19199});
    tick(8);
    bad = 0;
    for (int i = 0; i < 19200; i++)
      if (mark + i >= wlog.size() || wlog[mark + i] !== {15'(i), 3'b010}) bad++;
    chk("e_clear_seq_errors", bad, 0);
    chk("e_nwrites", wlog.size() - mark, 19201);
    if (wlog.size() > mark + 19200) chk("e_pend_last", wlog[mark + 19200], pend_exp);
    chk("e_ready_after", wr_ready, 1);

    // reset during a clear stops all writes
    hcount = 10'd0; vcount = 10'd100;
    clr_req = 1'b1; clr_rgb = 3'b001;
    tick(1);
    clr_req = 1'b0;
    tick(100);
    chk("f_busy", clr_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("f_we", ram_we, 0);
    chk("f_busy_rst", clr_busy, 0);
    mark = wlog.size();
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("f_ready", wr_ready, 1);
    tick(200);
    chk("f_no_writes", wlog.size() - mark, 0);
    chk("f_idle", clr_busy, 0);

    chk("display_slot_writes", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
